// File: rtl/icache_flush_seq_pkg.sv
// rtl/icache_flush_seq_pkg.sv - shared types for the icache flush sequencer
// Contents: flush_state_e, the 2-bit sequencer state (IDLE, DRAIN, FLUSH, ACK).
package icache_flush_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        ACK   = 2'd3
    } flush_state_e;

endpackage

// File: rtl/icache_flush_sequencer_if.sv
// rtl/icache_flush_sequencer_if.sv - core/fetch/cache-side signals of the flush sequencer
// Ports (slave = sequencer side):
//   core_flush_valid_i / core_flush_ready_o  per-core flush request / one-cycle acknowledge
//   fetch_req_i, fetch_gnt_i, fetch_rvalid_i  gated fetch traffic as seen by the cache
//   fetch_block_o                             per-port fetch block, ANDed (inverted) into core requests
//   cache_flush_valid_o / cache_flush_ready_i single flush handshake towards the cache
//   busy_o                                    sequencer not idle
interface icache_flush_sequencer_if #(
    parameter int unsigned NumFetchPorts = 8
);

    logic [NumFetchPorts-1:0] core_flush_valid_i;
    logic [NumFetchPorts-1:0] core_flush_ready_o;
    logic [NumFetchPorts-1:0] fetch_req_i;
    logic [NumFetchPorts-1:0] fetch_gnt_i;
    logic [NumFetchPorts-1:0] fetch_rvalid_i;
    logic [NumFetchPorts-1:0] fetch_block_o;
    logic                     cache_flush_valid_o;
    logic                     cache_flush_ready_i;
    logic                     busy_o;

    modport slave (
        input  core_flush_valid_i, fetch_req_i, fetch_gnt_i, fetch_rvalid_i, cache_flush_ready_i,
        output core_flush_ready_o, fetch_block_o, cache_flush_valid_o, busy_o
    );

    modport master (
        output core_flush_valid_i, fetch_req_i, fetch_gnt_i, fetch_rvalid_i, cache_flush_ready_i,
        input  core_flush_ready_o, fetch_block_o, cache_flush_valid_o, busy_o
    );

endinterface

// File: rtl/icache_fetch_outstanding_cnt.sv
// rtl/icache_fetch_outstanding_cnt.sv - saturating up/down count of outstanding fetches on one port
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   inc_i, dec_i   grant accepted / response returned this cycle
//   count_o        registered outstanding count
//   is_zero_o      count after this cycle's inc/dec will be zero
//   is_full_o      count after this cycle's inc/dec will be MaxOutstanding
module icache_fetch_outstanding_cnt #(
    parameter  int unsigned MaxOutstanding = 2,
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] count_o,
    output logic                is_zero_o,
    output logic                is_full_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    logic [CntWidth-1:0] count_q;
    logic [CntWidth-1:0] count_d;

    // Saturate at both ends; illegal over/underflow is flagged by the parent's assertions.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != CntMax)) begin
            count_d = count_q + CntWidth'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags look one cycle ahead so the registered block and the drain exit line up with the count.
    assign count_o   = count_q;
    assign is_zero_o = (count_d == '0);
    assign is_full_o = (count_d == CntMax);

endmodule

// File: rtl/icache_flush_sequencer.sv
// rtl/icache_flush_sequencer.sv - orders icache flushes so none overlaps an in-flight fetch
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     icache_flush_sequencer_if.slave (core flush handshakes, fetch traffic, cache flush handshake)
module icache_flush_sequencer
    import icache_flush_seq_pkg::*;
#(
    parameter int unsigned NumFetchPorts  = 8,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    icache_flush_sequencer_if.slave bus
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    flush_state_e             state_q, state_d;
    logic [NumFetchPorts-1:0] snapshot_q, snapshot_d;
    logic [NumFetchPorts-1:0] block_q, block_d;
    logic [NumFetchPorts-1:0] fetch_inc;
    logic [NumFetchPorts-1:0] next_zero;
    logic [NumFetchPorts-1:0] next_full;
    logic [CntWidth-1:0]      cnt [NumFetchPorts];

    assign fetch_inc = bus.fetch_req_i & bus.fetch_gnt_i;

    for (genvar i = 0; i < NumFetchPorts; i++) begin : g_port
        icache_fetch_outstanding_cnt #(
            .MaxOutstanding(MaxOutstanding)
        ) u_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .inc_i    (fetch_inc[i]),
            .dec_i    (bus.fetch_rvalid_i[i]),
            .count_o  (cnt[i]),
            .is_zero_o(next_zero[i]),
            .is_full_o(next_full[i])
        );

        a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (bus.fetch_rvalid_i[i] && !fetch_inc[i]) |-> (cnt[i] != '0));

        a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (fetch_inc[i] && !bus.fetch_rvalid_i[i]) |-> (cnt[i] != CntWidth'(MaxOutstanding)));
    end

    // DRAIN exits on the post-update counts: a grant this cycle keeps us draining,
    // while the last response lets FLUSH start on the very next cycle.
    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.core_flush_valid_i) begin
                    snapshot_d = bus.core_flush_valid_i;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (&next_zero) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (bus.cache_flush_ready_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                snapshot_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign block_d = {NumFetchPorts{state_d != IDLE}} | next_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            snapshot_q <= '0;
            block_q    <= '0;
        end else begin
            state_q    <= state_d;
            snapshot_q <= snapshot_d;
            block_q    <= block_d;
        end
    end

    assign bus.core_flush_ready_o  = (state_q == ACK) ? snapshot_q : '0;
    assign bus.cache_flush_valid_o = (state_q == FLUSH);
    assign bus.busy_o              = (state_q != IDLE);
    assign bus.fetch_block_o       = block_q;

    // Cores in the round must hold their request until acknowledged.
    a_snapshot_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != IDLE) |-> ((snapshot_q & ~bus.core_flush_valid_i) == '0));

endmodule

// File: tb/tb_icache_flush_sequencer.sv
// tb/tb_icache_flush_sequencer.sv - self-checking bench for icache_flush_sequencer
module tb_icache_flush_sequencer;

    localparam int unsigned NP = 8;
    localparam int unsigned MO = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_flush_sequencer_if #(.NumFetchPorts(NP)) ifc ();

    icache_flush_sequencer #(
        .NumFetchPorts (NP),
        .MaxOutstanding(MO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ifc.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard of expected acknowledge masks, popped when the DUT pulses core_flush_ready_o.
    logic [NP-1:0] exp_ack_q[$];
    logic [NP-1:0] sb_exp;
    logic [NP-1:0] last_ack = '0;
    int            sb_checks = 0;
    int            sb_fails  = 0;
    int            hs_count  = 0;

    always @(negedge clk) begin
        last_ack = ifc.core_flush_ready_o;
        if (rst_n && ifc.cache_flush_valid_o && ifc.cache_flush_ready_i) hs_count++;
        if (ifc.core_flush_ready_o != '0) begin
            sb_checks++;
            if (exp_ack_q.size() == 0) begin
                sb_fails++;
                $display("FAIL sb_ack: got %h, expected no acknowledge", ifc.core_flush_ready_o);
            end else begin
                sb_exp = exp_ack_q.pop_front();
                if (ifc.core_flush_ready_o !== sb_exp) begin
                    sb_fails++;
                    $display("FAIL sb_ack: got %h, expected %h", ifc.core_flush_ready_o, sb_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Advance to just after the next rising edge; cores drop requests acknowledged last cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        ifc.core_flush_valid_i = ifc.core_flush_valid_i & ~last_ack;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.core_flush_valid_i  = '0;
        ifc.fetch_req_i         = '0;
        ifc.fetch_gnt_i         = '0;
        ifc.fetch_rvalid_i      = '0;
        ifc.cache_flush_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (ifc.core_flush_ready_o !== 8'h00) begin n_fail++; $display("FAIL reset_ready: got %h, expected 00", ifc.core_flush_ready_o); end
        n_tests++; if (ifc.fetch_block_o !== 8'h00) begin n_fail++; $display("FAIL reset_block: got %h, expected 00", ifc.fetch_block_o); end
        n_tests++; if (ifc.cache_flush_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cache_valid: got %b, expected 0", ifc.cache_flush_valid_o); end
        n_tests++; if (ifc.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", ifc.busy_o); end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_tests++; if (ifc.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b, expected 0", ifc.busy_o); end
    endtask

    task automatic test_idle_flush();
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] exp_blk;
        tick();
        ifc.core_flush_valid_i = 8'h08;
        exp_ack_q.push_back(8'h08);
        @(negedge clk);
        n_tests++; if (ifc.fetch_block_o !== 8'h00) begin n_fail++; $display("FAIL idle_c0_block: got %h, expected 00", ifc.fetch_block_o); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk);
            exp_rdy = (c == 3) ? 8'h08 : 8'h00;
            exp_blk = (c <= 3) ? 8'hFF : 8'h00;
            n_tests++; if (ifc.cache_flush_valid_o !== (c == 2)) begin n_fail++; $display("FAIL idle_cache_valid c%0d: got %b, expected %b", c, ifc.cache_flush_valid_o, (c == 2)); end
            n_tests++; if (ifc.core_flush_ready_o !== exp_rdy) begin n_fail++; $display("FAIL idle_ready c%0d: got %h, expected %h", c, ifc.core_flush_ready_o, exp_rdy); end
            n_tests++; if (ifc.fetch_block_o !== exp_blk) begin n_fail++; $display("FAIL idle_block c%0d: got %h, expected %h", c, ifc.fetch_block_o, exp_blk); end
        end
    endtask

    task automatic test_drain();
        tick(); ifc.fetch_req_i = 8'h01; ifc.fetch_gnt_i = 8'h01;
        tick();
        tick(); ifc.fetch_req_i = 8'h00; ifc.fetch_gnt_i = 8'h00;
        ifc.core_flush_valid_i = 8'h02;
        exp_ack_q.push_back(8'h02);
        @(negedge clk);
        n_tests++; if (ifc.fetch_block_o !== 8'h01) begin n_fail++; $display("FAIL drain_full_block: got %h, expected 01", ifc.fetch_block_o); end
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            n_tests++; if (ifc.busy_o !== 1'b1 || ifc.cache_flush_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_hold c%0d: got busy %b valid %b, expected busy 1 valid 0", c, ifc.busy_o, ifc.cache_flush_valid_o); end
            n_tests++; if (ifc.fetch_block_o !== 8'hFF) begin n_fail++; $display("FAIL drain_block c%0d: got %h, expected ff", c, ifc.fetch_block_o); end
        end
        tick(); ifc.fetch_rvalid_i = 8'h01;
        @(negedge clk);
        n_tests++; if (ifc.cache_flush_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_rv1: got %b, expected 0", ifc.cache_flush_valid_o); end
        tick(); ifc.fetch_rvalid_i = 8'h00;
        @(negedge clk);
        n_tests++; if (ifc.cache_flush_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_gap: got %b, expected 0", ifc.cache_flush_valid_o); end
        tick(); ifc.fetch_rvalid_i = 8'h01;
        @(negedge clk);
        n_tests++; if (ifc.cache_flush_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_rv2: got %b, expected 0", ifc.cache_flush_valid_o); end
        tick(); ifc.fetch_rvalid_i = 8'h00;
        @(negedge clk);
        n_tests++; if (ifc.cache_flush_valid_o !== 1'b1) begin n_fail++; $display("FAIL drain_flush_rise: got %b, expected 1", ifc.cache_flush_valid_o); end
        tick();
        @(negedge clk);
        n_tests++; if (ifc.core_flush_ready_o !== 8'h02) begin n_fail++; $display("FAIL drain_ack: got %h, expected 02", ifc.core_flush_ready_o); end
        tick();
        @(negedge clk);
        n_tests++; if (ifc.busy_o !== 1'b0 || ifc.fetch_block_o !== 8'h00) begin n_fail++; $display("FAIL drain_end: got busy %b block %h, expected busy 0 block 00", ifc.busy_o, ifc.fetch_block_o); end
    endtask

    task automatic test_multi();
        int hs0;
        hs0 = hs_count;
        tick();
        ifc.core_flush_valid_i = 8'h21;
        exp_ack_q.push_back(8'h21);
        exp_ack_q.push_back(8'h04);
        @(negedge clk);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 2) ifc.core_flush_valid_i = ifc.core_flush_valid_i | 8'h04;
            @(negedge clk);
            if (c == 3) begin n_tests++; if (ifc.core_flush_ready_o !== 8'h21) begin n_fail++; $display("FAIL multi_ack1: got %h, expected 21", ifc.core_flush_ready_o); end end
            if (c == 4) begin n_tests++; if (ifc.busy_o !== 1'b0) begin n_fail++; $display("FAIL multi_idle_gap: got busy %b, expected 0", ifc.busy_o); end end
            if (c == 5) begin n_tests++; if (ifc.busy_o !== 1'b1) begin n_fail++; $display("FAIL multi_round2_start: got busy %b, expected 1", ifc.busy_o); end end
            if (c == 7) begin n_tests++; if (ifc.core_flush_ready_o !== 8'h04) begin n_fail++; $display("FAIL multi_ack2: got %h, expected 04", ifc.core_flush_ready_o); end end
        end
        n_tests++; if ((hs_count - hs0) !== 2) begin n_fail++; $display("FAIL multi_handshakes: got %0d, expected 2", hs_count - hs0); end
        n_tests++; if (ifc.busy_o !== 1'b0) begin n_fail++; $display("FAIL multi_end_busy: got %b, expected 0", ifc.busy_o); end
    endtask

    task automatic test_slow_cache();
        int            vcnt;
        logic [NP-1:0] exp_rdy;
        vcnt = 0;
        tick();
        ifc.cache_flush_ready_i = 1'b0;
        ifc.core_flush_valid_i  = 8'h40;
        exp_ack_q.push_back(8'h40);
        @(negedge clk);
        for (int c = 1; c <= 14; c++) begin
            tick();
            ifc.cache_flush_ready_i = (c >= 12);
            @(negedge clk);
            if (ifc.cache_flush_valid_o === 1'b1) vcnt++;
            exp_rdy = (c == 13) ? 8'h40 : 8'h00;
            n_tests++; if (ifc.core_flush_ready_o !== exp_rdy) begin n_fail++; $display("FAIL slow_ready c%0d: got %h, expected %h", c, ifc.core_flush_ready_o, exp_rdy); end
        end
        n_tests++; if (vcnt !== 11) begin n_fail++; $display("FAIL slow_valid_cycles: got %0d, expected 11", vcnt); end
    endtask

    task automatic test_backpressure();
        tick(); ifc.fetch_req_i = 8'h10; ifc.fetch_gnt_i = 8'h10;
        tick();
        tick(); ifc.fetch_req_i = 8'h00; ifc.fetch_gnt_i = 8'h00;
        @(negedge clk);
        n_tests++; if (ifc.fetch_block_o !== 8'h10 || ifc.busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_full: got block %h busy %b, expected block 10 busy 0", ifc.fetch_block_o, ifc.busy_o); end
        tick(); ifc.fetch_rvalid_i = 8'h10;
        @(negedge clk);
        n_tests++; if (ifc.fetch_block_o !== 8'h10) begin n_fail++; $display("FAIL bp_rv_same_cycle: got %h, expected 10", ifc.fetch_block_o); end
        tick(); ifc.fetch_rvalid_i = 8'h00;
        @(negedge clk);
        n_tests++; if (ifc.fetch_block_o !== 8'h00) begin n_fail++; $display("FAIL bp_release: got %h, expected 00", ifc.fetch_block_o); end
        tick(); ifc.fetch_req_i = 8'h10; ifc.fetch_gnt_i = 8'h10; ifc.fetch_rvalid_i = 8'h10;
        tick(); ifc.fetch_req_i = 8'h00; ifc.fetch_gnt_i = 8'h00; ifc.fetch_rvalid_i = 8'h00;
        @(negedge clk);
        n_tests++; if (ifc.fetch_block_o !== 8'h00) begin n_fail++; $display("FAIL bp_gnt_rv: got %h, expected 00", ifc.fetch_block_o); end
        tick(); ifc.fetch_req_i = 8'h10; ifc.fetch_gnt_i = 8'h10;
        tick(); ifc.fetch_req_i = 8'h00; ifc.fetch_gnt_i = 8'h00;
        @(negedge clk);
        n_tests++; if (ifc.fetch_block_o !== 8'h10) begin n_fail++; $display("FAIL bp_count_was_one: got %h, expected 10", ifc.fetch_block_o); end
        tick(); ifc.fetch_rvalid_i = 8'h10;
        tick();
        tick(); ifc.fetch_rvalid_i = 8'h00;
        @(negedge clk);
        n_tests++; if (ifc.fetch_block_o !== 8'h00) begin n_fail++; $display("FAIL bp_drained: got %h, expected 00", ifc.fetch_block_o); end
    endtask

    task automatic test_reset_mid_flush();
        logic [NP-1:0] exp_rdy;
        tick();
        ifc.cache_flush_ready_i = 1'b0;
        ifc.core_flush_valid_i  = 8'h80;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (ifc.cache_flush_valid_o === 1'b1) break;
            tick();
        end
        n_tests++; if (ifc.cache_flush_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_wait_flush: got %b, expected 1 within 10 cycles", ifc.cache_flush_valid_o); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (ifc.cache_flush_valid_o !== 1'b0 || ifc.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_async: got valid %b busy %b, expected 0 0", ifc.cache_flush_valid_o, ifc.busy_o); end
        n_tests++; if (ifc.fetch_block_o !== 8'h00 || ifc.core_flush_ready_o !== 8'h00) begin n_fail++; $display("FAIL rst_async_vec: got block %h ready %h, expected 00 00", ifc.fetch_block_o, ifc.core_flush_ready_o); end
        ifc.core_flush_valid_i  = '0;
        ifc.cache_flush_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); ifc.fetch_req_i = 8'h04; ifc.fetch_gnt_i = 8'h04;
        tick();
        tick(); ifc.fetch_req_i = 8'h00; ifc.fetch_gnt_i = 8'h00;
        @(negedge clk);
        n_tests++; if (ifc.fetch_block_o !== 8'h04) begin n_fail++; $display("FAIL rst_preload: got %h, expected 04", ifc.fetch_block_o); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (ifc.fetch_block_o !== 8'h00) begin n_fail++; $display("FAIL rst_block_clear: got %h, expected 00", ifc.fetch_block_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ifc.core_flush_valid_i = 8'h02;
        exp_ack_q.push_back(8'h02);
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk);
            exp_rdy = (c == 3) ? 8'h02 : 8'h00;
            n_tests++; if (ifc.core_flush_ready_o !== exp_rdy) begin n_fail++; $display("FAIL rst_counter_zero c%0d: got %h, expected %h", c, ifc.core_flush_ready_o, exp_rdy); end
        end
        n_tests++; if (ifc.fetch_block_o !== 8'h00) begin n_fail++; $display("FAIL rst_final_block: got %h, expected 00", ifc.fetch_block_o); end
    endtask

    initial begin
        test_reset();
        test_idle_flush();
        test_drain();
        test_multi();
        test_slow_cache();
        test_backpressure();
        test_reset_mid_flush();
        repeat (2) tick();
        n_tests++; if (sb_checks !== 6) begin n_fail++; $display("FAIL sb_count: got %0d acknowledges, expected 6", sb_checks); end
        n_tests++; if (sb_fails !== 0 || exp_ack_q.size() !== 0) begin n_fail++; $display("FAIL sb_final: got %0d bad acks and %0d pending, expected 0 and 0", sb_fails, exp_ack_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
